// File: rtl/ecc_apb_master.sv
// ============================================================================
// ecc_apb_master : sequences one ECC command into four APB register writes,
//                  then waits for the ECC completion pulse or a timeout.
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ecc_apb_master #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [1:0]                 cmd_width,
   input  logic [AMBA_WORD-1:0]       cmd_data,
   input  logic [AMBA_WORD-1:0]       cmd_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [1:0]                 rsp_errors,
   output logic [1:0]                 rsp_status
);

   localparam int             CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]     C_OP_ILLEGAL  = 2'b11;
   localparam logic [1:0]     C_ST_OK       = 2'b00;
   localparam logic [1:0]     C_ST_TIMEOUT  = 2'b01;
   localparam logic [1:0]     C_ST_ILLEGAL  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SETUP     = 3'd1,
      S_ACCESS    = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESP      = 3'd4
   } state_t;

   state_t                 r_state;
   logic [1:0]             r_op;
   logic [1:0]             r_width;
   logic [AMBA_WORD-1:0]   r_data;
   logic [AMBA_WORD-1:0]   r_noise;
   logic [1:0]             r_idx;
   logic [CNT_W-1:0]       r_wait_cnt;

   logic [1:0]             w_width;
   logic [1:0]             w_idx_next;
   logic [AMBA_WORD-1:0]   w_wdata_next;

   // Write order: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL (CTRL last starts the ECC block)
   function automatic logic [AMBA_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
      logic [AMBA_ADDR_WIDTH-1:0] a;
      case (idx)
         2'd0:    a = AMBA_ADDR_WIDTH'(8'h04);
         2'd1:    a = AMBA_ADDR_WIDTH'(8'h08);
         2'd2:    a = AMBA_ADDR_WIDTH'(8'h0C);
         default: a = AMBA_ADDR_WIDTH'(8'h00);
      endcase
      return a;
   endfunction

   assign w_width    = (cmd_width == 2'b11) ? 2'b10 : cmd_width;
   assign w_idx_next = r_idx + 2'd1;

   always_comb begin
      w_wdata_next = '0;
      case (w_idx_next)
         2'd0:    w_wdata_next = r_data;
         2'd1:    w_wdata_next = AMBA_WORD'(r_width);
         2'd2:    w_wdata_next = r_noise;
         default: w_wdata_next = AMBA_WORD'(r_op);
      endcase
   end

   // Gated by rst so no command is accepted while reset is asserted
   assign cmd_ready = (r_state == S_IDLE) && rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_op       <= 2'b00;
         r_width    <= 2'b00;
         r_data     <= '0;
         r_noise    <= '0;
         r_idx      <= 2'd0;
         r_wait_cnt <= '0;
         PADDR      <= '0;
         PWDATA     <= '0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_errors <= 2'b00;
         rsp_status <= C_ST_OK;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= cmd_op;
                  r_width <= w_width;
                  r_data  <= cmd_data;
                  r_noise <= cmd_noise;
                  r_idx   <= 2'd0;
                  if (cmd_op == C_OP_ILLEGAL) begin
                     r_state    <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_status <= C_ST_ILLEGAL;
                     rsp_data   <= '0;
                     rsp_errors <= 2'b00;
                  end else begin
                     r_state <= S_SETUP;
                     PSEL    <= 1'b1;
                     PENABLE <= 1'b0;
                     PWRITE  <= 1'b1;
                     PADDR   <= addr_of(2'd0);
                     PWDATA  <= cmd_data;
                  end
               end
            end

            S_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= S_ACCESS;
            end

            S_ACCESS: begin
               r_idx <= w_idx_next;
               if (r_idx == 2'd3) begin
                  r_state    <= S_WAIT_DONE;
                  PSEL       <= 1'b0;
                  PENABLE    <= 1'b0;
                  PWRITE     <= 1'b0;
                  r_wait_cnt <= '0;
               end else begin
                  r_state <= S_SETUP;
                  PENABLE <= 1'b0;
                  PADDR   <= addr_of(w_idx_next);
                  PWDATA  <= w_wdata_next;
               end
            end

            S_WAIT_DONE: begin
               // A completion arriving on the final timeout cycle still counts as success
               if (operation_done) begin
                  r_state    <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= C_ST_OK;
                  rsp_data   <= data_out;
                  rsp_errors <= num_of_errors;
               end else if (r_wait_cnt == C_CNT_MAX) begin
                  r_state    <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= C_ST_TIMEOUT;
                  rsp_data   <= '0;
                  rsp_errors <= 2'b00;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/ecc_apb_master.md
ECC_APB_MASTER -- requirements
Module: ecc_apb_master

Interface
REQ-001 Parameter AMBA_ADDR_WIDTH, default 20, SHALL set PADDR width.
REQ-002 Parameter AMBA_WORD, default 32, SHALL set PWDATA, cmd_data and cmd_noise width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set data_out and rsp_data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum WAIT_DONE dwell in cycles.
REQ-005 Ports SHALL be:
clk  in  1  sole clock, rising edge
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 encode, 01 decode, 10 full channel, 11 illegal
cmd_width  in  2  codeword width code 00=8, 01=16, 10=32, 11 coerced to 10
cmd_data  in  AMBA_WORD  DATA_IN register value
cmd_noise  in  AMBA_WORD  NOISE register value
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
operation_done  in  1  ECC block completion pulse
data_out  in  DATA_WIDTH  ECC result data
num_of_errors  in  2  ECC error count
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when high with rsp_valid
rsp_data  out  DATA_WIDTH  captured data_out
rsp_errors  out  2  captured num_of_errors
rsp_status  out  2  00 ok, 01 timeout, 10 illegal op

Function
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT_DONE, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-007 On handshake in cycle T, command fields SHALL be registered; op 11 goes to RESP at T+1 with rsp_status=10, rsp_data=0, rsp_errors=0, no APB traffic.
REQ-008 Legal command SHALL issue four APB writes in order: DATA_IN @0x04 (cmd_data), CODEWORD_WIDTH @0x08 ({30'b0,width}), NOISE @0x0C (cmd_noise), CTRL @0x00 ({30'b0,op}).
REQ-009 Each write SHALL take two cycles: SETUP (PSEL=1, PENABLE=0) then ACCESS (PSEL=1, PENABLE=1); PADDR/PWDATA/PWRITE=1 stable across both.
REQ-010 Writes SHALL be back-to-back: PSEL high T+1..T+8, PENABLE high on T+2,T+4,T+6,T+8; PSEL=PENABLE=0 from T+9.
REQ-011 A 2-bit write index SHALL advance on each ACCESS; ACCESS with index 3 SHALL go to WAIT_DONE.
REQ-012 Outside transfers PSEL=PENABLE=PWRITE=0, PADDR and PWDATA hold last value.
REQ-013 operation_done SHALL be ignored outside WAIT_DONE.
REQ-014 In WAIT_DONE a counter SHALL start at 0 on entry and increment each cycle; operation_done=1 SHALL capture data_out and num_of_errors and enter RESP with rsp_status=00 next cycle.
REQ-015 Counter reaching TIMEOUT_CYCLES-1 without operation_done SHALL enter RESP with rsp_status=01, rsp_data=0, rsp_errors=0; operation_done on that same cycle SHALL win (status 00).
REQ-016 RESP SHALL hold rsp_valid=1 and response fields stable until rsp_ready=1, then return to IDLE next cycle.
REQ-017 rsp_valid SHALL be 0 in all states except RESP; best-case legal latency handshake to rsp_valid is 10 cycles (done at T+9).

Reset
REQ-018 rst=0 sampled at a rising edge SHALL force IDLE next cycle regardless of state, including mid-transfer.
REQ-019 Reset values: cmd_ready=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_data=0, rsp_errors=0, rsp_status=00, counters 0.
REQ-020 Commands offered during reset SHALL NOT be accepted; cmd_ready reads 1 only from the first cycle rst=1.

Verification
REQ-021 Encode op=00, width=10, data=0xA5A5_1234, noise=0; done at T+9 with data_out=0x1234_5678, errors=0 -> writes 0x04,0x08,0x0C,0x00 at T+1..T+8, rsp_valid at T+10, rsp_data=0x1234_5678, status 00.
REQ-022 Decode with operation_done pulsed at T+5 and T+12 -> T+5 pulse ignored, capture at T+12, rsp_valid at T+13.
REQ-023 TIMEOUT_CYCLES=16, no operation_done -> rsp_valid at T+25, rsp_status=01, rsp_data=0.
REQ-024 cmd_op=11 -> no PSEL activity, rsp_valid at T+1, rsp_status=10; cmd_width=11 legal op -> CODEWORD_WIDTH write data 0x2.
REQ-025 rst=0 during ACCESS of NOISE write -> PSEL=PENABLE=0 next cycle, cmd_ready=1 once rst=1, no response emitted.
REQ-026 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
